// File: rtl/bram0_loader_if.sv
// -----------------------------------------------------------------------------
// bram0_loader_if
//
// Purpose: bundles the byte stream handshake feeding the BRAM0 loader together
// with the BRAM0 write-port signals the loader drives.
//
// Signals:
//   s_valid_i  stream byte valid            (host -> loader)
//   s_data_i   stream byte                  (host -> loader)
//   s_ready_o  loader accepts a byte        (loader -> host)
//   addr_o     BRAM0 row address            (loader -> BRAM0)
//   ce_o       BRAM0 chip enable            (loader -> BRAM0)
//   we_o       BRAM0 write enable, 1=write  (loader -> BRAM0)
//   d_o        BRAM0 write data             (loader -> BRAM0)
//
// Modports: slave = loader side, master = host/BRAM side.
// -----------------------------------------------------------------------------
interface bram0_loader_if #(
    parameter int IN_DATA_WIDTH = 8,
    parameter int AWIDTH        = 8,
    parameter int DWIDTH        = 32
);
    logic                     s_valid_i;
    logic [IN_DATA_WIDTH-1:0] s_data_i;
    logic                     s_ready_o;
    logic [AWIDTH-1:0]        addr_o;
    logic                     ce_o;
    logic                     we_o;
    logic [DWIDTH-1:0]        d_o;

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        output s_ready_o,
        output addr_o,
        output ce_o,
        output we_o,
        output d_o
    );

    modport master (
        output s_valid_i,
        output s_data_i,
        input  s_ready_o,
        input  addr_o,
        input  ce_o,
        input  we_o,
        input  d_o
    );
endinterface

// File: rtl/bram0_loader.sv
// -----------------------------------------------------------------------------
// bram0_loader
//
// Purpose: fills BRAM0 from a valid/ready byte stream, packing four bytes per
// row (first byte in lane 0) and writing rows sequentially from address 0.
// Reports idle/load/done status to the run controller.
//
// Ports:
//   clk            clock, rising edge
//   reset_n        asynchronous reset, active low
//   start_load_i   one-cycle start pulse, only honoured in IDLE
//   load_count_i   number of bytes to load, latched on start
//   bus            bram0_loader_if.slave: stream in, BRAM0 write port out
//   idle_o         state is IDLE
//   load_o         state is LOAD or WAIT
//   done_o         state is DONE (one cycle)
//   checksum_o     (only with BRAM0_LOADER_CHECKSUM_EN) 16-bit sum of the
//                  bytes accepted in the current load
//
// Optional feature macro: BRAM0_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module bram0_loader #(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 8,
    parameter int MEM_SIZE      = 256,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_load_i,
    input  logic [CNT_BIT-1:0] load_count_i,
    bram0_loader_if.slave      bus,
    output logic               idle_o,
    output logic               load_o,
`ifdef BRAM0_LOADER_CHECKSUM_EN
    output logic [15:0]        checksum_o,
`endif
    output logic               done_o
);
    localparam int LANES  = DWIDTH / IN_DATA_WIDTH;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Rows beyond the address space would alias silently; catch a bad
    // configuration at elaboration instead.
    if (MEM_SIZE > (1 << AWIDTH)) begin : g_bad_mem_size
        $error("bram0_loader: MEM_SIZE exceeds 2**AWIDTH");
    end

    logic [1:0]         state_q,  state_d;
    logic [CNT_BIT-1:0] count_q,  count_d;   // latched byte count
    logic [CNT_BIT-1:0] cnt_q,    cnt_d;     // bytes accepted so far
    logic [LANE_W-1:0]  lane_q,   lane_d;
    logic [AWIDTH-1:0]  row_q,    row_d;     // next row to write
    logic [DWIDTH-1:0]  pack_q,   pack_d;
    logic [AWIDTH-1:0]  addr_q,   addr_d;
    logic [DWIDTH-1:0]  data_q,   data_d;
    logic               wr_q,     wr_d;

    logic               accept;
    logic               last_byte;
    logic               lane_full;
    logic [DWIDTH-1:0]  pack_ins;            // pack register with the incoming byte merged

    assign bus.s_ready_o = (state_q == ST_LOAD) && (cnt_q < count_q);
    assign accept        = bus.s_valid_i && bus.s_ready_o;
    assign last_byte     = ((cnt_q + CNT_BIT'(1)) == count_q);
    assign lane_full     = (lane_q == LANE_W'(LANES - 1));

    // Drop the incoming byte into the lane currently being filled.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign pack_ins[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH] =
            (lane_q == LANE_W'(gi)) ? bus.s_data_i
                                    : pack_q[gi*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    end

`ifdef BRAM0_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    assign checksum_o = csum_q;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        row_d   = row_q;
        pack_d  = pack_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
`ifdef BRAM0_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_load_i) begin
                    count_d = load_count_i;
                    cnt_d   = '0;
                    lane_d  = '0;
                    row_d   = '0;
                    pack_d  = '0;
                    state_d = (load_count_i == '0) ? ST_DONE : ST_LOAD;
`ifdef BRAM0_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_BIT'(1);
`ifdef BRAM0_LOADER_CHECKSUM_EN
                    csum_d = csum_q + 16'(bus.s_data_i);
`endif
                    // A row goes out when its last lane fills or the stream
                    // ends; unused lanes stay zero because pack clears.
                    if (lane_full || last_byte) begin
                        wr_d   = 1'b1;
                        addr_d = row_q;
                        data_d = pack_ins;
                        row_d  = row_q + AWIDTH'(1);
                        pack_d = '0;
                        lane_d = '0;
                    end else begin
                        pack_d = pack_ins;
                        lane_d = lane_q + LANE_W'(1);
                    end
                    if (last_byte) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            row_q   <= '0;
            pack_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
`ifdef BRAM0_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            row_q   <= row_d;
            pack_q  <= pack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
`ifdef BRAM0_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.addr_o = addr_q;
    assign bus.d_o    = data_q;
    assign bus.ce_o   = wr_q;
    assign bus.we_o   = wr_q;

    assign idle_o = (state_q == ST_IDLE);
    assign load_o = (state_q == ST_LOAD) || (state_q == ST_WAIT);
    assign done_o = (state_q == ST_DONE);
endmodule

// File: tb/tb_bram0_loader.sv
// -----------------------------------------------------------------------------
// tb_bram0_loader
//
// Directed bench for bram0_loader. dut1 uses the default geometry; dut2 uses a
// 2-bit address so row wraparound can be exercised with a short stream.
// -----------------------------------------------------------------------------
module tb_bram0_loader;
    logic        clk;
    logic        reset_n;
    logic        start1, start2;
    logic [30:0] count1, count2;
    logic        idle1, load1, done1;
    logic        idle2, load2, done2;
`ifdef BRAM0_LOADER_CHECKSUM_EN
    logic [15:0] csum1, csum2;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    bram0_loader_if #(.IN_DATA_WIDTH(8), .AWIDTH(8), .DWIDTH(32)) bus1 ();
    bram0_loader_if #(.IN_DATA_WIDTH(8), .AWIDTH(2), .DWIDTH(32)) bus2 ();

    bram0_loader #(.CNT_BIT(31), .DWIDTH(32), .AWIDTH(8), .MEM_SIZE(256), .IN_DATA_WIDTH(8)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_load_i (start1),
        .load_count_i (count1),
        .bus          (bus1.slave),
        .idle_o       (idle1),
        .load_o       (load1),
`ifdef BRAM0_LOADER_CHECKSUM_EN
        .checksum_o   (csum1),
`endif
        .done_o       (done1)
    );

    bram0_loader #(.CNT_BIT(31), .DWIDTH(32), .AWIDTH(2), .MEM_SIZE(4), .IN_DATA_WIDTH(8)) dut2 (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_load_i (start2),
        .load_count_i (count2),
        .bus          (bus2.slave),
        .idle_o       (idle2),
        .load_o       (load2),
`ifdef BRAM0_LOADER_CHECKSUM_EN
        .checksum_o   (csum2),
`endif
        .done_o       (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitors: log every BRAM write pulse, sampled mid-cycle.
    int          wr1_cnt = 0;
    int          wr2_cnt = 0;
    logic [7:0]  wa1 [64];
    logic [31:0] wd1 [64];
    logic [1:0]  wa2 [64];
    logic [31:0] wd2 [64];

    always @(negedge clk) begin
        if (bus1.ce_o && bus1.we_o) begin
            if (wr1_cnt < 64) begin
                wa1[wr1_cnt] = bus1.addr_o;
                wd1[wr1_cnt] = bus1.d_o;
            end
            wr1_cnt++;
        end
        if (bus2.ce_o && bus2.we_o) begin
            if (wr2_cnt < 64) begin
                wa2[wr2_cnt] = bus2.addr_o;
                wd2[wr2_cnt] = bus2.d_o;
            end
            wr2_cnt++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tests_run++; if (idle1 !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %0b expected 1", idle1); end
        tests_run++; if ({load1, done1, bus1.s_ready_o, bus1.ce_o, bus1.we_o} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: got %05b expected 00000", {load1, done1, bus1.s_ready_o, bus1.ce_o, bus1.we_o}); end
        tests_run++; if ({bus1.addr_o, bus1.d_o} !== 40'h0) begin tests_failed++; $display("FAIL reset_bus: got addr %0h d %0h expected 0/0", bus1.addr_o, bus1.d_o); end
        tests_run++; if (idle2 !== 1'b1) begin tests_failed++; $display("FAIL reset_idle2: got %0b expected 1", idle2); end
`ifdef BRAM0_LOADER_CHECKSUM_EN
        tests_run++; if (csum1 !== 16'h0) begin tests_failed++; $display("FAIL reset_csum: got %0h expected 0", csum1); end
`endif
        $display("[TB] reset: idle=%0b load=%0b done=%0b", idle1, load1, done1);
    endtask

    task automatic test_full_rows;
        int base;
        base   = wr1_cnt;
        start1 = 1'b1; count1 = 31'd8;
        step;
        start1 = 1'b0;
        tests_run++; if (load1 !== 1'b1) begin tests_failed++; $display("FAIL full_load: got %0b expected 1", load1); end
        for (int i = 0; i < 8; i++) begin
            bus1.s_valid_i = 1'b1;
            bus1.s_data_i  = 8'(i + 1);
            tests_run++; if (bus1.s_ready_o !== 1'b1) begin tests_failed++; $display("FAIL full_ready%0d: got %0b expected 1", i, bus1.s_ready_o); end
            step;
        end
        bus1.s_valid_i = 1'b0;
        // T+1: final write pulse, state WAIT
        tests_run++; if ({bus1.ce_o, bus1.we_o, load1, done1} !== 4'b1110) begin tests_failed++; $display("FAIL full_t1_flags: got %04b expected 1110", {bus1.ce_o, bus1.we_o, load1, done1}); end
        tests_run++; if (bus1.addr_o !== 8'd1 || bus1.d_o !== 32'h08070605) begin tests_failed++; $display("FAIL full_t1_row: got %0h/%08h expected 1/08070605", bus1.addr_o, bus1.d_o); end
        step; // T+2
        tests_run++; if ({done1, bus1.ce_o, load1} !== 3'b100) begin tests_failed++; $display("FAIL full_t2_done: got %03b expected 100", {done1, bus1.ce_o, load1}); end
        tests_run++; if (bus1.addr_o !== 8'd1 || bus1.d_o !== 32'h08070605) begin tests_failed++; $display("FAIL full_hold: got %0h/%08h expected 1/08070605", bus1.addr_o, bus1.d_o); end
        step; // T+3
        tests_run++; if ({idle1, done1} !== 2'b10) begin tests_failed++; $display("FAIL full_t3_idle: got %02b expected 10", {idle1, done1}); end
        tests_run++; if (wr1_cnt - base !== 2) begin tests_failed++; $display("FAIL full_nwr: got %0d expected 2", wr1_cnt - base); end
        tests_run++; if (wa1[base] !== 8'd0 || wd1[base] !== 32'h04030201) begin tests_failed++; $display("FAIL full_row0: got %0h/%08h expected 0/04030201", wa1[base], wd1[base]); end
        tests_run++; if (wa1[base+1] !== 8'd1 || wd1[base+1] !== 32'h08070605) begin tests_failed++; $display("FAIL full_row1: got %0h/%08h expected 1/08070605", wa1[base+1], wd1[base+1]); end
        $display("[TB] full_rows: writes=%0d row0=%08h row1=%08h", wr1_cnt - base, wd1[base], wd1[base+1]);
    endtask

    task automatic test_partial_gaps;
        int         base;
        int         k;
        logic [7:0] pb [6];
        pb     = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        base   = wr1_cnt;
        k      = 0;
        start1 = 1'b1; count1 = 31'd6;
        step;
        start1 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c % 2 == 0) begin
                bus1.s_valid_i = 1'b1;
                bus1.s_data_i  = pb[k];
                k++;
            end else begin
                bus1.s_valid_i = 1'b0;
                bus1.s_data_i  = 8'h99;
            end
            step;
        end
        // T+1 after 6th accept; offer a 7th byte that must be refused
        bus1.s_valid_i = 1'b1;
        bus1.s_data_i  = 8'h77;
        tests_run++; if (bus1.s_ready_o !== 1'b0) begin tests_failed++; $display("FAIL part_ready_drop: got %0b expected 0", bus1.s_ready_o); end
        tests_run++; if (bus1.ce_o !== 1'b1 || bus1.addr_o !== 8'd1 || bus1.d_o !== 32'h0000FFEE) begin tests_failed++; $display("FAIL part_t1_row: got ce %0b %0h/%08h expected 1 1/0000ffee", bus1.ce_o, bus1.addr_o, bus1.d_o); end
        step;
        tests_run++; if (done1 !== 1'b1 || bus1.s_ready_o !== 1'b0) begin tests_failed++; $display("FAIL part_done: got done %0b ready %0b expected 1/0", done1, bus1.s_ready_o); end
        step;
        step;
        bus1.s_valid_i = 1'b0;
        tests_run++; if (idle1 !== 1'b1) begin tests_failed++; $display("FAIL part_idle: got %0b expected 1", idle1); end
        tests_run++; if (wr1_cnt - base !== 2) begin tests_failed++; $display("FAIL part_nwr: got %0d expected 2", wr1_cnt - base); end
        tests_run++; if (wa1[base] !== 8'd0 || wd1[base] !== 32'hDDCCBBAA) begin tests_failed++; $display("FAIL part_row0: got %0h/%08h expected 0/ddccbbaa", wa1[base], wd1[base]); end
        tests_run++; if (wa1[base+1] !== 8'd1 || wd1[base+1] !== 32'h0000FFEE) begin tests_failed++; $display("FAIL part_row1: got %0h/%08h expected 1/0000ffee", wa1[base+1], wd1[base+1]); end
        $display("[TB] partial_gaps: writes=%0d row0=%08h row1=%08h", wr1_cnt - base, wd1[base], wd1[base+1]);
    endtask

    task automatic test_zero_and_ignore;
        int         base;
        logic [7:0] pb [4];
        pb     = '{8'h11, 8'h22, 8'h33, 8'h44};
        base   = wr1_cnt;
        start1 = 1'b1; count1 = 31'd0;
        step;
        start1 = 1'b0;
        tests_run++; if ({done1, bus1.ce_o, bus1.we_o, load1} !== 4'b1000) begin tests_failed++; $display("FAIL zero_done: got %04b expected 1000", {done1, bus1.ce_o, bus1.we_o, load1}); end
        step;
        tests_run++; if ({idle1, done1} !== 2'b10) begin tests_failed++; $display("FAIL zero_idle: got %02b expected 10", {idle1, done1}); end
        tests_run++; if (wr1_cnt !== base) begin tests_failed++; $display("FAIL zero_nowr: got %0d expected %0d", wr1_cnt, base); end
        // count=4, then a second start with count=8 during LOAD must be ignored
        start1 = 1'b1; count1 = 31'd4;
        step;
        for (int i = 0; i < 4; i++) begin
            start1         = (i == 1);
            count1         = (i == 1) ? 31'd8 : 31'd4;
            bus1.s_valid_i = 1'b1;
            bus1.s_data_i  = pb[i];
            step;
        end
        start1         = 1'b0;
        bus1.s_data_i  = 8'h55;
        tests_run++; if (bus1.s_ready_o !== 1'b0 || load1 !== 1'b1) begin tests_failed++; $display("FAIL ign_ready: got ready %0b load %0b expected 0/1", bus1.s_ready_o, load1); end
        tests_run++; if (bus1.ce_o !== 1'b1 || bus1.addr_o !== 8'd0 || bus1.d_o !== 32'h44332211) begin tests_failed++; $display("FAIL ign_row: got ce %0b %0h/%08h expected 1 0/44332211", bus1.ce_o, bus1.addr_o, bus1.d_o); end
        step;
        tests_run++; if (done1 !== 1'b1) begin tests_failed++; $display("FAIL ign_done: got %0b expected 1", done1); end
        step;
        bus1.s_valid_i = 1'b0;
        tests_run++; if (wr1_cnt - base !== 1) begin tests_failed++; $display("FAIL ign_nwr: got %0d expected 1", wr1_cnt - base); end
        $display("[TB] zero_and_ignore: writes=%0d row=%08h", wr1_cnt - base, bus1.d_o);
    endtask

    task automatic test_reset_mid_load;
        int base;
        base   = wr1_cnt;
        start1 = 1'b1; count1 = 31'd8;
        step;
        start1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus1.s_valid_i = 1'b1;
            bus1.s_data_i  = 8'hA1 + 8'(i);
            step;
        end
        bus1.s_valid_i = 1'b0;
        reset_n = 1'b0;
        #1;
        tests_run++; if ({idle1, load1, done1, bus1.s_ready_o, bus1.ce_o, bus1.we_o} !== 6'b100000) begin tests_failed++; $display("FAIL rst_mid_flags: got %06b expected 100000", {idle1, load1, done1, bus1.s_ready_o, bus1.ce_o, bus1.we_o}); end
        tests_run++; if (bus1.addr_o !== 8'd0 || bus1.d_o !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_bus: got %0h/%08h expected 0/0", bus1.addr_o, bus1.d_o); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus1.s_valid_i = 1'b1;
            bus1.s_data_i  = 8'hB0 + 8'(i);
            step;
        end
        bus1.s_valid_i = 1'b0;
        tests_run++; if (idle1 !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_idle: got %0b expected 1", idle1); end
        tests_run++; if (wr1_cnt - base !== 1) begin tests_failed++; $display("FAIL rst_mid_nwr: got %0d expected 1", wr1_cnt - base); end
        tests_run++; if (wa1[base] !== 8'd0 || wd1[base] !== 32'hA4A3A2A1) begin tests_failed++; $display("FAIL rst_mid_row0: got %0h/%08h expected 0/a4a3a2a1", wa1[base], wd1[base]); end
        $display("[TB] reset_mid_load: writes=%0d row0=%08h", wr1_cnt - base, wd1[base]);
    endtask

    task automatic test_wrap;
        int         base;
        logic [1:0] exp_addr [5];
        exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        base     = wr2_cnt;
        start2   = 1'b1; count2 = 31'd20;
        step;
        start2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus2.s_valid_i = 1'b1;
            bus2.s_data_i  = 8'(i + 1);
            step;
        end
        bus2.s_valid_i = 1'b0;
        step;
        step;
        tests_run++; if (idle2 !== 1'b1) begin tests_failed++; $display("FAIL wrap_idle: got %0b expected 1", idle2); end
        tests_run++; if (wr2_cnt - base !== 5) begin tests_failed++; $display("FAIL wrap_nwr: got %0d expected 5", wr2_cnt - base); end
        for (int r = 0; r < 5; r++) begin
            tests_run++; if (wa2[base+r] !== exp_addr[r]) begin tests_failed++; $display("FAIL wrap_addr%0d: got %0d expected %0d", r, wa2[base+r], exp_addr[r]); end
        end
        tests_run++; if (wd2[base+4] !== 32'h14131211) begin tests_failed++; $display("FAIL wrap_row4: got %08h expected 14131211", wd2[base+4]); end
        tests_run++; if (wd2[base+1] !== 32'h08070605) begin tests_failed++; $display("FAIL wrap_row1: got %08h expected 08070605", wd2[base+1]); end
        $display("[TB] wrap: writes=%0d last addr=%0d data=%08h", wr2_cnt - base, wa2[base+4], wd2[base+4]);
    endtask

`ifdef BRAM0_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] pb [4];
        pb     = '{8'hFF, 8'hFF, 8'hFF, 8'h03};
        start1 = 1'b1; count1 = 31'd4;
        step;
        start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus1.s_valid_i = 1'b1;
            bus1.s_data_i  = pb[i];
            step;
        end
        bus1.s_valid_i = 1'b0;
        step;
        tests_run++; if (done1 !== 1'b1 || csum1 !== 16'h0300) begin tests_failed++; $display("FAIL csum_done: got done %0b csum %04h expected 1/0300", done1, csum1); end
        step;
        tests_run++; if (idle1 !== 1'b1 || csum1 !== 16'h0300) begin tests_failed++; $display("FAIL csum_hold: got idle %0b csum %04h expected 1/0300", idle1, csum1); end
        $display("[TB] checksum: csum=%04h", csum1);
    endtask
`endif

    initial begin
        reset_n        = 1'b0;
        start1         = 1'b0; count1 = '0;
        start2         = 1'b0; count2 = '0;
        bus1.s_valid_i = 1'b0; bus1.s_data_i = '0;
        bus2.s_valid_i = 1'b0; bus2.s_data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        reset_n = 1'b1;
        step;
        test_full_rows;
        test_partial_gaps;
        test_zero_and_ignore;
        test_reset_mid_load;
        test_wrap;
`ifdef BRAM0_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
